// File: rtl/pt8211_pkg.sv
// Shared definitions for the PT8211 serial audio receiver.
package pt8211_pkg;

  localparam int unsigned WORD_BITS_DEFAULT = 16;

  localparam logic LEFT  = 1'b1;
  localparam logic RIGHT = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HUNT  = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/pt8211_sync.sv
// Input synchronizers for ws/bck/din plus bck-rise and ws-edge detection.
module pt8211_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ws,
  input  logic bck,
  input  logic din,
  output logic ws_lvl,
  output logic din_lvl,
  output logic bck_rise,
  output logic ws_edge
);

  logic [SYNC_STAGES-1:0] ws_sr;
  logic [SYNC_STAGES-1:0] bck_sr;
  logic [SYNC_STAGES-1:0] din_sr;
  logic                   ws_prev;
  logic                   bck_prev;

  // All three chains are the same depth so a din/ws change made with bck stays aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      ws_sr    <= '0;
      bck_sr   <= '0;
      din_sr   <= '0;
      ws_prev  <= 1'b0;
      bck_prev <= 1'b0;
    end else begin
      ws_sr[0]  <= ws;
      bck_sr[0] <= bck;
      din_sr[0] <= din;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        ws_sr[i]  <= ws_sr[i-1];
        bck_sr[i] <= bck_sr[i-1];
        din_sr[i] <= din_sr[i-1];
      end
      ws_prev  <= ws_sr[SYNC_STAGES-1];
      bck_prev <= bck_sr[SYNC_STAGES-1];
    end
  end

  assign ws_lvl   = ws_sr[SYNC_STAGES-1];
  assign din_lvl  = din_sr[SYNC_STAGES-1];
  assign bck_rise = bck_sr[SYNC_STAGES-1] & ~bck_prev;
  assign ws_edge  = ws_sr[SYNC_STAGES-1] ^ ws_prev;

endmodule

// File: rtl/pt8211_rx.sv
// PT8211-style serial audio receiver: word framing FSM, link watchdog and
// valid/ready output holding one received word.
module pt8211_rx
  import pt8211_pkg::*;
#(
  parameter int unsigned WORD_BITS     = WORD_BITS_DEFAULT,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned TIMEOUT_TICKS = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pt8211_ws,
  input  logic                 pt8211_bck,
  input  logic                 pt8211_din,
  output logic [WORD_BITS-1:0] sample_data,
  output logic                 sample_left,
  output logic                 sample_valid,
  input  logic                 sample_ready,
  output logic                 link_active,
  output logic                 frame_error,
  output logic                 overflow
);

  localparam int unsigned BW = $clog2(WORD_BITS + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);

  logic                 ws_lvl;
  logic                 din_lvl;
  logic                 bck_rise;
  logic                 ws_edge;

  rx_state_t            state;
  logic [WORD_BITS-2:0] shreg;
  logic [WORD_BITS-1:0] shift_word;
  logic [BW-1:0]        bit_cnt;
  logic [TW-1:0]        idle_cnt;
  logic                 chan;
  logic                 timeout;
  logic                 last_bit;

  pt8211_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .ws      (pt8211_ws),
    .bck     (pt8211_bck),
    .din     (pt8211_din),
    .ws_lvl  (ws_lvl),
    .din_lvl (din_lvl),
    .bck_rise(bck_rise),
    .ws_edge (ws_edge)
  );

  assign shift_word  = {shreg, din_lvl};
  assign timeout     = (idle_cnt == TW'(TIMEOUT_TICKS));
  assign last_bit    = (bit_cnt == BW'(WORD_BITS - 1));
  assign link_active = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      idle_cnt     <= '0;
      chan         <= RIGHT;
      sample_data  <= '0;
      sample_left  <= 1'b0;
      sample_valid <= 1'b0;
      frame_error  <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      overflow    <= 1'b0;

      if (bck_rise) begin
        idle_cnt <= '0;
      end else if (!timeout) begin
        idle_cnt <= idle_cnt + TW'(1);
      end

      if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end

      if (state != IDLE && timeout) begin
        state   <= IDLE;
        bit_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bck_rise) begin
              state <= HUNT;
            end
          end
          HUNT, SHIFT, HOLD: begin
            // A ws edge outranks a coincident bck rise; that rise becomes bit 0.
            if (ws_edge) begin
              if (state == SHIFT && bit_cnt != '0) begin
                frame_error <= 1'b1;
              end
              state <= SHIFT;
              chan  <= ws_lvl;
              if (bck_rise) begin
                shreg   <= shift_word[WORD_BITS-2:0];
                bit_cnt <= BW'(1);
              end else begin
                bit_cnt <= '0;
              end
            end else if (state == SHIFT && bck_rise) begin
              shreg <= shift_word[WORD_BITS-2:0];
              if (last_bit) begin
                state   <= HOLD;
                bit_cnt <= '0;
                // Replacing a word accepted this same cycle is not an overflow.
                if (!sample_valid || sample_ready) begin
                  sample_data  <= shift_word;
                  sample_left  <= chan;
                  sample_valid <= 1'b1;
                end else begin
                  overflow <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
